// File: rtl/lsu_bus_master_if.sv
// Memory-stage request/response and system bus signals for lsu_bus_master.
// master: the LSU side (drives req_ready, resp_*, bus_* except bus_rdata).
interface lsu_bus_master_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd_en;
  logic        bus_wr_en;
  logic [31:0] bus_rdata;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata,
    input  req_size, req_unsigned, bus_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output bus_addr, bus_wdata, bus_rd_en, bus_wr_en
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata,
    output req_size, req_unsigned, bus_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  bus_addr, bus_wdata, bus_rd_en, bus_wr_en
  );
endinterface

// File: rtl/lsu_bus_master.sv
// Load/store bus master: one request at a time, single-cycle bus strobe,
// load lane extraction/extension, and spacing of UART-window stores.
// Ports: clk, reset (async, active-low), m (lsu_bus_master_if.master).
// Option: define LSU_ALIGN_CHECK_EN to report misaligned accesses.
module lsu_bus_master #(
  parameter logic [31:0] UART_BASE  = 32'h0000_3000,
  parameter logic [31:0] UART_LIMIT = 32'h0000_4000,
  parameter int unsigned UART_GAP   = 16
) (
  input  logic             clk,
  input  logic             reset,
  lsu_bus_master_if.master m
);

  typedef enum logic [1:0] {
    IDLE, HOLD, ISSUE, RESP
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic        uart_q, uart_d;
  logic [7:0]  gap_q, gap_d, gap_dec;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        resp_q, resp_d;
  logic        rerr_q, rerr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;

  logic        is_byte, is_half;
  logic        misal, in_uart;
  logic [31:0] addr_al, wdata_pl;
  logic [31:0] rd_sh, rd_ext;

  assign is_byte = m.req_size == 2'b00;
  assign is_half = m.req_size == 2'b01;
  assign in_uart = (m.req_addr >= UART_BASE)
                && (m.req_addr < UART_LIMIT);

`ifdef LSU_ALIGN_CHECK_EN
  assign misal = (is_half & m.req_addr[0])
              | (~is_byte & ~is_half
                 & (m.req_addr[1:0] != 2'b00));
  assign addr_al = m.req_addr;
`else
  assign misal = 1'b0;
  always_comb begin
    addr_al = m.req_addr;
    unique case (1'b1)
      is_byte: addr_al = m.req_addr;
      is_half: addr_al[0] = 1'b0;
      default: addr_al[1:0] = 2'b00;
    endcase
  end
`endif

  // No byte enables: replicate narrow store data across all lanes.
  always_comb begin
    unique case (1'b1)
      is_byte: wdata_pl = {4{m.req_wdata[7:0]}};
      is_half: wdata_pl = {2{m.req_wdata[15:0]}};
      default: wdata_pl = m.req_wdata;
    endcase
  end

  assign rd_sh = m.bus_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    unique case (1'b1)
      size_q == 2'b00:
        rd_ext = {{24{~uns_q & rd_sh[7]}}, rd_sh[7:0]};
      size_q == 2'b01:
        rd_ext = {{16{~uns_q & rd_sh[15]}}, rd_sh[15:0]};
      default:
        rd_ext = m.bus_rdata;
    endcase
  end

  // gap_dec is the counter value after this edge; deciding on it
  // makes strobe-to-strobe spacing exactly UART_GAP cycles.
  assign gap_dec = gap_q - {7'd0, gap_q != 8'd0};

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    uart_d  = uart_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    gap_d   = gap_dec;
    unique case (state_q)
      IDLE: begin
        if (m.req_valid) begin
          we_d    = m.req_we;
          size_d  = m.req_size;
          uns_d   = m.req_unsigned;
          addr_d  = addr_al;
          wdata_d = wdata_pl;
          err_d   = misal;
          uart_d  = m.req_we & in_uart;
          if (misal) begin
            state_d = RESP;
            rdata_d = '0;
          end else if (m.req_we && in_uart
                       && gap_dec != 8'd0) begin
            state_d = HOLD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      HOLD: begin
        if (gap_dec == 8'd0) state_d = ISSUE;
      end
      ISSUE: begin
        state_d = RESP;
        rdata_d = we_d ? '0 : rd_ext;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == ISSUE && uart_d) gap_d = 8'(UART_GAP);
    ready_d = state_d == IDLE;
    resp_d  = state_d == RESP;
    rerr_d  = (state_d == RESP) && err_d;
    rd_d    = (state_d == ISSUE) && !we_d;
    wr_d    = (state_d == ISSUE) && we_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      uart_q  <= 1'b0;
      gap_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rerr_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      uart_q  <= uart_d;
      gap_q   <= gap_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
      rerr_q  <= rerr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  assign m.req_ready  = ready_q;
  assign m.resp_valid = resp_q;
  assign m.resp_rdata = rdata_q;
  assign m.resp_err   = rerr_q;
  assign m.bus_addr   = addr_q;
  assign m.bus_wdata  = wdata_q;
  assign m.bus_rd_en  = rd_q;
  assign m.bus_wr_en  = wr_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Bench for lsu_bus_master: vector table of single accesses plus
// hand-written reset-during-HOLD sequence.
module tb_lsu_bus_master;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  time  last_uart;

  lsu_bus_master_if u_if ();

  lsu_bus_master #(
    .UART_BASE  (32'h0000_3000),
    .UART_LIMIT (32'h0000_4000),
    .UART_GAP   (16)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .m     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic [31:0] x_rdata;
    int          x_wait;
    int          x_gap;
  } vec_t;

  vec_t vt [17];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    u_if.req_valid    = 1'b1;
    u_if.req_we       = v.we;
    u_if.req_addr     = v.addr;
    u_if.req_wdata    = v.wdata;
    u_if.req_size     = v.size;
    u_if.req_unsigned = v.uns;
    u_if.bus_rdata    = v.rdata;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int  w;
    logic is_uart;
    is_uart = v.we && v.addr >= 32'h3000 && v.addr < 32'h4000;
    @(negedge clk);
    drive_req(v);
    w = 0;
    while (!u_if.req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " ready"}, 32'(u_if.req_ready), 32'd1);
    @(posedge clk);
    #1;
    u_if.req_valid = 1'b0;
    if (v.err) begin
      chk({nm, " strobe"},
          32'({u_if.bus_rd_en, u_if.bus_wr_en}), 32'd0);
      chk({nm, " resp_valid"}, 32'(u_if.resp_valid), 32'd1);
      chk({nm, " resp_err"}, 32'(u_if.resp_err), 32'd1);
      chk({nm, " rdata"}, u_if.resp_rdata, 32'd0);
      @(posedge clk);
      #1;
      chk({nm, " resp_end"}, 32'(u_if.resp_valid), 32'd0);
      chk({nm, " ready_back"}, 32'(u_if.req_ready), 32'd1);
    end else begin
      if (v.x_wait != 0)
        chk({nm, " hold_ready"}, 32'(u_if.req_ready), 32'd0);
      w = 0;
      while (!(u_if.bus_rd_en || u_if.bus_wr_en) && w < 40) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk({nm, " wait"}, 32'(w), 32'(v.x_wait));
      if (v.x_gap != 0)
        chk({nm, " gap"}, 32'(($time - last_uart) / 10),
            32'(v.x_gap));
      if (is_uart) last_uart = $time;
      chk({nm, " strobe"},
          32'({u_if.bus_rd_en, u_if.bus_wr_en}),
          v.we ? 32'd1 : 32'd2);
      chk({nm, " bus_addr"}, u_if.bus_addr, v.x_addr);
      chk({nm, " bus_wdata"}, u_if.bus_wdata, v.x_wdata);
      @(posedge clk);
      #1;
      chk({nm, " resp_valid"}, 32'(u_if.resp_valid), 32'd1);
      chk({nm, " resp_err"}, 32'(u_if.resp_err), 32'd0);
      chk({nm, " rdata"}, u_if.resp_rdata, v.x_rdata);
      chk({nm, " strobe_end"},
          32'({u_if.bus_rd_en, u_if.bus_wr_en}), 32'd0);
      @(posedge clk);
      #1;
      chk({nm, " resp_end"}, 32'(u_if.resp_valid), 32'd0);
      chk({nm, " ready_back"}, 32'(u_if.req_ready), 32'd1);
    end
  endtask

  initial begin
    vec_t v;
    logic quiet;
    checks    = 0;
    errors    = 0;
    last_uart = 0;

    vt[0]  = '{1'b0, 2'd0, 1'b0, 32'h3000, 32'h0, 32'h0000_0080,
               1'b0, 32'h3000, 32'h0, 32'hFFFF_FF80, 0, 0};
    vt[1]  = '{1'b0, 2'd0, 1'b1, 32'h3000, 32'h0, 32'h0000_0080,
               1'b0, 32'h3000, 32'h0, 32'h0000_0080, 0, 0};
    vt[2]  = '{1'b0, 2'd1, 1'b0, 32'h1002, 32'h0, 32'h8001_1234,
               1'b0, 32'h1002, 32'h0, 32'hFFFF_8001, 0, 0};
    vt[3]  = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 32'h8001_1234,
               1'b0, 32'h1000, 32'h0, 32'h8001_1234, 0, 0};
    vt[4]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 32'h8012_3456,
               1'b0, 32'h1003, 32'h0, 32'hFFFF_FF80, 0, 0};
    vt[5]  = '{1'b0, 2'd0, 1'b0, 32'h1001, 32'h0, 32'h8012_3456,
               1'b0, 32'h1001, 32'h0, 32'h0000_0034, 0, 0};
    vt[6]  = '{1'b0, 2'd1, 1'b1, 32'h1002, 32'h0, 32'h8001_1234,
               1'b0, 32'h1002, 32'h0, 32'h0000_8001, 0, 0};
    vt[7]  = '{1'b1, 2'd0, 1'b0, 32'h3000, 32'h41, 32'h0,
               1'b0, 32'h3000, 32'h4141_4141, 32'h0, 0, 0};
    vt[8]  = '{1'b1, 2'd0, 1'b0, 32'h3000, 32'h42, 32'h0,
               1'b0, 32'h3000, 32'h4242_4242, 32'h0, 13, 16};
    vt[9]  = '{1'b1, 2'd0, 1'b0, 32'h3000, 32'h43, 32'h0,
               1'b0, 32'h3000, 32'h4343_4343, 32'h0, 13, 16};
    vt[10] = '{1'b1, 2'd1, 1'b0, 32'h2000, 32'h0000_BEEF, 32'h0,
               1'b0, 32'h2000, 32'hBEEF_BEEF, 32'h0, 0, 0};
    vt[11] = '{1'b1, 2'd2, 1'b0, 32'h2004, 32'h1234_5678, 32'h0,
               1'b0, 32'h2004, 32'h1234_5678, 32'h0, 0, 0};
    vt[12] = '{1'b1, 2'd2, 1'b0, 32'h3FFC, 32'hDEAD_BEEF, 32'h0,
               1'b0, 32'h3FFC, 32'hDEAD_BEEF, 32'h0, 7, 16};
    vt[13] = '{1'b1, 2'd0, 1'b0, 32'h4000, 32'h5A, 32'h0,
               1'b0, 32'h4000, 32'h5A5A_5A5A, 32'h0, 0, 0};
    vt[14] = '{1'b1, 2'd0, 1'b0, 32'h2FFF, 32'hA5, 32'h0,
               1'b0, 32'h2FFF, 32'hA5A5_A5A5, 32'h0, 0, 0};
`ifdef LSU_ALIGN_CHECK_EN
    vt[15] = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'hCAFE_F00D,
               1'b1, 32'h0, 32'h0, 32'h0, 0, 0};
    vt[16] = '{1'b0, 2'd1, 1'b0, 32'h1003, 32'h0, 32'h8001_1234,
               1'b1, 32'h0, 32'h0, 32'h0, 0, 0};
`else
    vt[15] = '{1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'hCAFE_F00D,
               1'b0, 32'h3000, 32'h0, 32'hCAFE_F00D, 0, 0};
    vt[16] = '{1'b0, 2'd1, 1'b0, 32'h1003, 32'h0, 32'h8001_1234,
               1'b0, 32'h1002, 32'h0, 32'hFFFF_8001, 0, 0};
`endif

    rst_n             = 1'b0;
    u_if.req_valid    = 1'b0;
    u_if.req_we       = 1'b0;
    u_if.req_addr     = '0;
    u_if.req_wdata    = '0;
    u_if.req_size     = 2'b00;
    u_if.req_unsigned = 1'b0;
    u_if.bus_rdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", 32'(u_if.req_ready), 32'd1);
    chk("rst resp_valid", 32'(u_if.resp_valid), 32'd0);
    chk("rst resp_err", 32'(u_if.resp_err), 32'd0);
    chk("rst strobes",
        32'({u_if.bus_rd_en, u_if.bus_wr_en}), 32'd0);
    chk("rst rdata", u_if.resp_rdata, 32'd0);
    chk("rst bus_addr", u_if.bus_addr, 32'd0);
    chk("rst bus_wdata", u_if.bus_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    // Reset asserted while a UART store waits in HOLD.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    v = '{1'b1, 2'd0, 1'b0, 32'h3000, 32'h55, 32'h0,
          1'b0, 32'h3000, 32'h5555_5555, 32'h0, 0, 0};
    run_vec(v, "rst_pre");
    @(negedge clk);
    v.wdata = 32'h66;
    drive_req(v);
    @(posedge clk);
    #1;
    u_if.req_valid = 1'b0;
    chk("hold ready", 32'(u_if.req_ready), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("hold strobes",
          32'({u_if.bus_rd_en, u_if.bus_wr_en}), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst strobes",
        32'({u_if.bus_rd_en, u_if.bus_wr_en}), 32'd0);
    chk("mid_rst resp_valid", 32'(u_if.resp_valid), 32'd0);
    chk("mid_rst ready", 32'(u_if.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (u_if.resp_valid || u_if.bus_rd_en || u_if.bus_wr_en)
        quiet = 1'b0;
    end
    chk("post_rst quiet", 32'(quiet), 32'd1);
    chk("post_rst ready", 32'(u_if.req_ready), 32'd1);
    v.wdata   = 32'h77;
    v.x_wdata = 32'h7777_7777;
    run_vec(v, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
